// File: rtl/lane_frame_loader_pkg.sv
// Shared definitions for the lane frame loader: default geometry, FSM states
// and the bit positions inside frame_err.
package lane_frame_loader_pkg;

  localparam int NUM_LANES_DEF = 26;
  localparam int LANE_W_DEF    = 8;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/lane_frame_loader.sv
// Assembles a framed byte stream into a packed bank of NUM_LANES byte lanes and
// holds it for the downstream lanes; short frames are padded, long ones truncated.
module lane_frame_loader
  import lane_frame_loader_pkg::*;
#(
  parameter int                NUM_LANES = NUM_LANES_DEF,
  parameter int                LANE_W    = LANE_W_DEF,
  parameter logic [LANE_W-1:0] PAD_VALUE = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  input  logic [LANE_W-1:0]           in_data_i,
  input  logic                        in_last_i,
  output logic                        in_ready_o,
  output logic [NUM_LANES*LANE_W-1:0] lanes_o,
  output logic                        frame_valid_o,
  input  logic                        frame_ready_i,
  output logic [1:0]                  frame_err_o
);

  localparam int               IDX_W    = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [1:0]       err_reg, err_next;
  logic             accept;
  logic             lane_we;
  logic             pad_en;

  // Ready is withheld during reset so no byte can slip in on the reset edge.
  assign in_ready_o    = (state_reg != HOLD) && !rst_i;
  assign accept        = in_valid_i && in_ready_o;
  assign frame_valid_o = (state_reg == HOLD);
  assign frame_err_o   = err_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    lane_we    = 1'b0;
    pad_en     = 1'b0;
    case (state_reg)
      FILL: begin
        if (accept) begin
          lane_we = 1'b1;
          if (idx_reg == LAST_IDX) begin
            if (in_last_i) begin
              state_next = HOLD;
            end else begin
              state_next         = DRAIN;
              err_next[ERR_LONG] = 1'b1;
            end
          end else begin
            // idx saturates at LAST_IDX; it is rewound only when HOLD releases.
            idx_next = idx_reg + IDX_W'(1);
            if (in_last_i) begin
              pad_en              = 1'b1;
              err_next[ERR_SHORT] = 1'b1;
              state_next          = HOLD;
            end
          end
        end
      end
      DRAIN: begin
        if (accept && in_last_i) state_next = HOLD;
      end
      HOLD: begin
        if (frame_ready_i) begin
          state_next = FILL;
          idx_next   = '0;
          err_next   = '0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // One register per lane: written when idx points at it, padded when a short
  // frame terminates below it.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] lane_reg;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          lane_reg <= '0;
        end else if (lane_we && (idx_reg == IDX_W'(gi))) begin
          lane_reg <= in_data_i;
        end else if (pad_en && (idx_reg < IDX_W'(gi))) begin
          lane_reg <= PAD_VALUE;
        end
      end

      assign lanes_o[gi*LANE_W +: LANE_W] = lane_reg;
    end
  endgenerate

endmodule

// File: tb/tb_lane_frame_loader.sv
// Scoreboard bench for lane_frame_loader: a driver feeds framed bytes and queues
// the expected bank per frame; a monitor checks each presented frame.
module tb_lane_frame_loader;

  localparam int NL = 26;
  localparam int LW = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic [LW-1:0]    in_data_i;
  logic             in_last_i;
  logic             in_ready_o;
  logic [NL*LW-1:0] lanes_o;
  logic             frame_valid_o;
  logic             frame_ready_i;
  logic [1:0]       frame_err_o;

  always #5 clk = ~clk;

  lane_frame_loader dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_last_i     (in_last_i),
    .in_ready_o    (in_ready_o),
    .lanes_o       (lanes_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .frame_err_o   (frame_err_o)
  );

  typedef struct {
    logic [NL*LW-1:0] lanes;
    logic [1:0]       err;
    int               cyc;
  } exp_t;

  exp_t         sb[$];
  logic [7:0]   cur[$];
  logic [7:0]   fbuf[64];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           rdy_low_left = 0;
  bit           rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [NL*LW-1:0] act,
                                input logic [NL*LW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: a frame is the list of accepted bytes up to last; lanes take the
  // first NL bytes, missing lanes are zero, and the length sets the error code.
  task automatic model_accept(input logic [7:0] b, input logic last);
    exp_t e;
    cur.push_back(b);
    if (last) begin
      for (int k = 0; k < NL; k++)
        e.lanes[k*LW +: LW] = (k < cur.size()) ? cur[k] : 8'h00;
      e.err = (cur.size() < NL) ? 2'b01 : (cur.size() > NL) ? 2'b10 : 2'b00;
      e.cyc = cyc + 1;
      sb.push_back(e);
      $display("frame queued: len=%0d err=%b", cur.size(), e.err);
      cur.delete();
    end
  endtask

  // Drives fbuf[0..len-1]; abort_at > 0 pulses reset after that many accepts.
  task automatic send_frame(input int len, input int gap, input int abort_at);
    int i = 0;
    int guard = 0;
    while (i < len) begin
      @(negedge clk);
      if (abort_at > 0 && i == abort_at) begin
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        cur.delete();
        $display("reset pulsed after %0d bytes", i);
        @(negedge clk);
        rst_i = 1'b0;
        return;
      end
      guard++;
      if (guard > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL input_stall: got no accept in %0d cycles want accept", guard);
        return;
      end
      in_valid_i = ($urandom_range(99) >= gap);
      in_data_i  = fbuf[i];
      in_last_i  = (i == len - 1);
      if (in_valid_i && in_ready_o) begin
        model_accept(in_data_i, in_last_i);
        i++;
      end
    end
  endtask

  // Monitor: compares every presented frame cycle against the queue head.
  initial begin
    bit prev_valid = 1'b0;
    bit bubble = 1'b0;
    frame_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_i) begin
        check("ready_in_reset", in_ready_o, 0);
        bubble = 1'b0;
      end else if (bubble) begin
        check("bubble_valid", frame_valid_o, 0);
        check("bubble_ready", in_ready_o, 1);
      end
      bubble = 1'b0;
      if (frame_valid_o) begin
        check("hold_ready", in_ready_o, 0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame: got frame_valid_o=1 want 0");
        end else begin
          if (!prev_valid) check("latency", cyc, sb[0].cyc);
          check("lanes", lanes_o, sb[0].lanes);
          check("err", frame_err_o, sb[0].err);
        end
      end
      if (frame_valid_o && rdy_low_left > 0) begin
        frame_ready_i = 1'b0;
        rdy_low_left--;
      end else begin
        frame_ready_i = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (frame_valid_o && frame_ready_i) begin
        if (sb.size() > 0) void'(sb.pop_front());
        bubble = 1'b1;
      end
      prev_valid = frame_valid_o;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    rst_i      = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'h55;
    in_last_i  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_lanes", lanes_o, 0);
    check("reset_valid", frame_valid_o, 0);
    check("reset_err", frame_err_o, 0);
    rst_i      = 1'b0;
    in_valid_i = 1'b0;

    for (int k = 0; k < 26; k++) fbuf[k] = 8'(k + 1);
    send_frame(26, 0, 0);

    fbuf[0] = 8'hAA; fbuf[1] = 8'hBB; fbuf[2] = 8'hCC;
    send_frame(3, 0, 0);

    for (int k = 0; k < 30; k++) fbuf[k] = 8'(8'h10 + k);
    send_frame(30, 0, 0);

    rdy_low_left = 5;
    for (int k = 0; k < 26; k++) fbuf[k] = 8'($urandom);
    send_frame(26, 0, 0);
    for (int k = 0; k < 26; k++) fbuf[k] = 8'($urandom);
    send_frame(26, 0, 0);

    for (int k = 0; k < 26; k++) fbuf[k] = 8'(8'hE0 + k);
    send_frame(26, 0, 10);
    for (int k = 0; k < 26; k++) fbuf[k] = 8'(8'h40 + k);
    send_frame(26, 0, 0);

    fbuf[0] = 8'h7E;
    send_frame(1, 0, 0);

    rdy_rand = 1'b1;
    repeat (40) begin
      int len;
      len = $urandom_range(1, 34);
      for (int k = 0; k < len; k++) fbuf[k] = 8'($urandom);
      send_frame(len, $urandom_range(0, 40), 0);
    end

    @(negedge clk);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    waited = 0;
    while ((sb.size() != 0 || frame_valid_o) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
